// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the icache request and fills the IF/ID register.
// Latency: a hit in the request cycle lands on instr/npc/valid at the next edge; 1 instr/cycle on hits.
// Backpressure: stall holds IF/ID and PC with the request still asserted; a miss inserts bubbles.
module fetch_unit #(
  parameter logic [31:0] PC_INIT = 32'h00000000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic [31:0] instr,
  output logic [31:0] npc,
  output logic        valid,
  output logic        halted
);

  // SQUASH: a redirect arrived mid-miss, so the old request is finished
  // (address held stable) before jumping to the pending target.
  typedef enum logic [1:0] {FETCH, SQUASH, HALTED} state_t;

  state_t      r_state, w_state;
  logic [31:0] r_pc, w_pc;
  logic [31:0] r_pend_pc, w_pend_pc;
  logic [31:0] r_instr, w_instr;
  logic [31:0] r_npc, w_npc;
  logic        r_valid, w_valid;
  logic        r_miss, w_miss;   // previous cycle requested r_pc without a hit
  logic [31:0] w_pc_inc;
  logic [31:0] w_rpc;

  assign w_pc_inc = r_pc + 32'd4;
  // Targets are word aligned; low two bits are dropped.
  assign w_rpc    = redirect_pc & ~32'h3;

  assign imemREN  = (r_state != HALTED) && !RST;
  assign imemaddr = r_pc;
  assign instr    = r_instr;
  assign npc      = r_npc;
  assign valid    = r_valid;
  assign halted   = (r_state == HALTED);

  // Next-state and next IF/ID contents, priority ordered per state.
  always_comb begin
    w_state   = r_state;
    w_pc      = r_pc;
    w_pend_pc = r_pend_pc;
    w_instr   = r_instr;
    w_npc     = r_npc;
    w_valid   = r_valid;
    w_miss    = r_miss;
    case (r_state)
      FETCH: begin
        if (halt) begin
          w_state = HALTED;
          w_valid = 1'b0;
          w_instr = 32'd0;
          w_miss  = 1'b0;
        end else if (redirect && (ihit || !r_miss)) begin
          w_pc    = w_rpc;
          w_valid = 1'b0;
          w_instr = 32'd0;
          w_miss  = 1'b0;
        end else if (redirect) begin
          w_pend_pc = w_rpc;
          w_state   = SQUASH;
          w_valid   = 1'b0;
          w_instr   = 32'd0;
          w_miss    = 1'b0;
        end else if (stall) begin
          // Request stays up at the same address; track whether it is still missing.
          w_miss = !ihit;
        end else if (ihit) begin
          w_instr = imemload;
          w_npc   = w_pc_inc;
          w_valid = 1'b1;
          w_pc    = w_pc_inc;
          w_miss  = 1'b0;
        end else begin
          w_valid = 1'b0;
          w_instr = 32'd0;
          w_miss  = 1'b1;
        end
      end
      SQUASH: begin
        w_valid = 1'b0;
        if (halt) begin
          w_state = HALTED;
        end else if (ihit) begin
          // A redirect on the very cycle the stale word returns is the newest target.
          w_pc    = redirect ? w_rpc : r_pend_pc;
          w_state = FETCH;
        end else if (redirect) begin
          w_pend_pc = w_rpc;
        end
      end
      HALTED: begin
        w_valid = 1'b0;
      end
      default: begin
        w_state = FETCH;
      end
    endcase
  end

  // State and IF/ID registers; reset abandons any outstanding request.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= FETCH;
      r_pc      <= PC_INIT;
      r_pend_pc <= 32'd0;
      r_instr   <= 32'd0;
      r_npc     <= 32'd0;
      r_valid   <= 1'b0;
      r_miss    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_pc      <= w_pc;
      r_pend_pc <= w_pend_pc;
      r_instr   <= w_instr;
      r_npc     <= w_npc;
      r_valid   <= w_valid;
      r_miss    <= w_miss;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: table of per-cycle vectors with hand-derived expectations.
// Request-side outputs checked before each edge; IF/ID expectations queued and checked after it.
// Ends with a hand-written asynchronous reset sequence out of the halted state.
module tb_fetch_unit;

  logic        CLK;
  logic        RST;
  logic        ihit;
  logic [31:0] imemload;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic [31:0] instr;
  logic [31:0] npc;
  logic        valid;
  logic        halted;

  fetch_unit #(.PC_INIT(32'h00000000)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .imemload(imemload),
    .imemREN(imemREN), .imemaddr(imemaddr), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .instr(instr), .npc(npc), .valid(valid), .halted(halted)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst;
    logic        ih;
    logic [31:0] load;
    logic        st;
    logic        rd;
    logic [31:0] rpc;
    logic        hl;
    logic [31:0] addr;
    logic        ren;
    logic [31:0] ins;
    logic [31:0] npc;
    logic        v;
    logic        h;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] ins;
    logic [31:0] npc;
    logic        v;
    logic        h;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic add(input logic r, input logic ih, input logic [31:0] ld, input logic st,
                     input logic rd, input logic [31:0] rpc, input logic hl,
                     input logic [31:0] addr, input logic ren,
                     input logic [31:0] ins, input logic [31:0] np, input logic v, input logic h);
    vec_t e;
    e.rst = r; e.ih = ih; e.load = ld; e.st = st; e.rd = rd; e.rpc = rpc; e.hl = hl;
    e.addr = addr; e.ren = ren; e.ins = ins; e.npc = np; e.v = v; e.h = h;
    tbl.push_back(e);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    RST = 1'b1; ihit = 1'b0; imemload = 32'd0; stall = 1'b0;
    redirect = 1'b0; redirect_pc = 32'd0; halt = 1'b0;

    //   rst ih load          st rd rpc           hl  addr          ren ins           npc           v  h
    // continuous hits, then a reset mid-stream (pc was 0xC)
    add(0, 1, 32'h8C010004, 0, 0, 32'h0,        0, 32'h00000000, 1, 32'h8C010004, 32'h00000004, 1, 0);
    add(0, 1, 32'h00221820, 0, 0, 32'h0,        0, 32'h00000004, 1, 32'h00221820, 32'h00000008, 1, 0);
    add(0, 1, 32'hFFFFFFFF, 0, 0, 32'h0,        0, 32'h00000008, 1, 32'hFFFFFFFF, 32'h0000000C, 1, 0);
    add(1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h00000000, 0, 32'h0,        32'h00000000, 0, 0);
    add(0, 1, 32'h000000A0, 0, 0, 32'h0,        0, 32'h00000000, 1, 32'h000000A0, 32'h00000004, 1, 0);
    add(0, 1, 32'h000000A4, 0, 0, 32'h0,        0, 32'h00000004, 1, 32'h000000A4, 32'h00000008, 1, 0);
    add(0, 1, 32'h000000A8, 0, 0, 32'h0,        0, 32'h00000008, 1, 32'h000000A8, 32'h0000000C, 1, 0);
    add(0, 1, 32'h000000AC, 0, 0, 32'h0,        0, 32'h0000000C, 1, 32'h000000AC, 32'h00000010, 1, 0);
    // 3-cycle miss at 0x10
    add(0, 0, 32'hDEADBEEF, 0, 0, 32'h0,        0, 32'h00000010, 1, 32'h0,        32'h00000010, 0, 0);
    add(0, 0, 32'hDEADBEEF, 0, 0, 32'h0,        0, 32'h00000010, 1, 32'h0,        32'h00000010, 0, 0);
    add(0, 0, 32'hDEADBEEF, 0, 0, 32'h0,        0, 32'h00000010, 1, 32'h0,        32'h00000010, 0, 0);
    add(0, 1, 32'h22222222, 0, 0, 32'h0,        0, 32'h00000010, 1, 32'h22222222, 32'h00000014, 1, 0);
    // 2-cycle stall with hits
    add(0, 1, 32'h33333333, 1, 0, 32'h0,        0, 32'h00000014, 1, 32'h22222222, 32'h00000014, 1, 0);
    add(0, 1, 32'h33333333, 1, 0, 32'h0,        0, 32'h00000014, 1, 32'h22222222, 32'h00000014, 1, 0);
    add(0, 1, 32'h33333333, 0, 0, 32'h0,        0, 32'h00000014, 1, 32'h33333333, 32'h00000018, 1, 0);
    add(0, 1, 32'h44444444, 0, 0, 32'h0,        0, 32'h00000018, 1, 32'h44444444, 32'h0000001C, 1, 0);
    add(0, 1, 32'h55555555, 0, 0, 32'h0,        0, 32'h0000001C, 1, 32'h55555555, 32'h00000020, 1, 0);
    // redirect on hit at 0x20 -> 0x100
    add(0, 1, 32'h66666666, 0, 1, 32'h00000100, 0, 32'h00000020, 1, 32'h0,        32'h00000020, 0, 0);
    add(0, 1, 32'h77777777, 0, 0, 32'h0,        0, 32'h00000100, 1, 32'h77777777, 32'h00000104, 1, 0);
    // redirect to 0x40, miss 2 cycles, redirect to 0x200 during the miss
    add(0, 1, 32'h5A5A5A5A, 0, 1, 32'h00000040, 0, 32'h00000104, 1, 32'h0,        32'h00000104, 0, 0);
    add(0, 0, 32'h5A5A5A5A, 0, 0, 32'h0,        0, 32'h00000040, 1, 32'h0,        32'h00000104, 0, 0);
    add(0, 0, 32'h5A5A5A5A, 0, 0, 32'h0,        0, 32'h00000040, 1, 32'h0,        32'h00000104, 0, 0);
    add(0, 0, 32'h5A5A5A5A, 0, 1, 32'h00000200, 0, 32'h00000040, 1, 32'h0,        32'h00000104, 0, 0);
    add(0, 0, 32'h5A5A5A5A, 0, 0, 32'h0,        0, 32'h00000040, 1, 32'h0,        32'h00000104, 0, 0);
    add(0, 1, 32'h88888888, 0, 0, 32'h0,        0, 32'h00000040, 1, 32'h0,        32'h00000104, 0, 0);
    add(0, 1, 32'h99999999, 0, 0, 32'h0,        0, 32'h00000200, 1, 32'h99999999, 32'h00000204, 1, 0);
    // wrap at top of address space, then unaligned redirect target
    add(0, 1, 32'h5A5A5A5A, 0, 1, 32'hFFFFFFFC, 0, 32'h00000204, 1, 32'h0,        32'h00000204, 0, 0);
    add(0, 1, 32'hAAAAAAAA, 0, 0, 32'h0,        0, 32'hFFFFFFFC, 1, 32'hAAAAAAAA, 32'h00000000, 1, 0);
    add(0, 1, 32'hBBBBBBBB, 0, 0, 32'h0,        0, 32'h00000000, 1, 32'hBBBBBBBB, 32'h00000004, 1, 0);
    add(0, 1, 32'h5A5A5A5A, 0, 1, 32'h00000103, 0, 32'h00000004, 1, 32'h0,        32'h00000004, 0, 0);
    add(0, 1, 32'hCCCCCCCC, 0, 0, 32'h0,        0, 32'h00000100, 1, 32'hCCCCCCCC, 32'h00000104, 1, 0);
    // halt in FETCH; later hits/redirects ignored
    add(0, 1, 32'hDDDDDDDD, 0, 0, 32'h0,        1, 32'h00000104, 1, 32'h0,        32'h00000104, 0, 1);
    add(0, 1, 32'hEEEEEEEE, 0, 1, 32'h00000300, 0, 32'h0,        0, 32'h0,        32'h00000104, 0, 1);
    add(0, 1, 32'hEEEEEEEE, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h00000104, 0, 1);
    // reset out of HALTED, then halt while in SQUASH
    add(1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h00000000, 0, 32'h0,        32'h00000000, 0, 0);
    add(0, 1, 32'h12345678, 0, 0, 32'h0,        0, 32'h00000000, 1, 32'h12345678, 32'h00000004, 1, 0);
    add(0, 0, 32'h5A5A5A5A, 0, 0, 32'h0,        0, 32'h00000004, 1, 32'h0,        32'h00000004, 0, 0);
    add(0, 0, 32'h5A5A5A5A, 0, 1, 32'h00000500, 0, 32'h00000004, 1, 32'h0,        32'h00000004, 0, 0);
    add(0, 0, 32'h5A5A5A5A, 0, 0, 32'h0,        1, 32'h00000004, 1, 32'h0,        32'h00000004, 0, 1);
    add(0, 1, 32'h5A5A5A5A, 0, 1, 32'h00000600, 0, 32'h0,        0, 32'h0,        32'h00000004, 0, 1);

    // reset state
    repeat (2) @(negedge CLK);
    chk("rst_ren",    -1, {31'd0, imemREN}, 32'd0);
    chk("rst_addr",   -1, imemaddr, 32'h0);
    chk("rst_instr",  -1, instr, 32'h0);
    chk("rst_npc",    -1, npc, 32'h0);
    chk("rst_valid",  -1, {31'd0, valid}, 32'd0);
    chk("rst_halted", -1, {31'd0, halted}, 32'd0);

    foreach (tbl[i]) begin
      RST = tbl[i].rst; ihit = tbl[i].ih; imemload = tbl[i].load; stall = tbl[i].st;
      redirect = tbl[i].rd; redirect_pc = tbl[i].rpc; halt = tbl[i].hl;
      #1;
      chk("imemREN", i, {31'd0, imemREN}, {31'd0, tbl[i].ren});
      if (tbl[i].ren || tbl[i].rst) chk("imemaddr", i, imemaddr, tbl[i].addr);
      e.idx = i; e.ins = tbl[i].ins; e.npc = tbl[i].npc; e.v = tbl[i].v; e.h = tbl[i].h;
      sb.push_back(e);
      @(posedge CLK);
      #1;
      if (sb.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL scoreboard_empty vec %0d: got 0 entries expected 1", i);
      end else begin
        e = sb.pop_front();
        chk("instr",  e.idx, instr, e.ins);
        chk("npc",    e.idx, npc, e.npc);
        chk("valid",  e.idx, {31'd0, valid}, {31'd0, e.v});
        chk("halted", e.idx, {31'd0, halted}, {31'd0, e.h});
      end
      @(negedge CLK);
    end

    // Asynchronous reset away from any clock edge clears halted and restarts at PC_INIT.
    ihit = 1'b0; redirect = 1'b0; halt = 1'b0;
    #2 RST = 1'b1;
    #1;
    chk("async_halted", -2, {31'd0, halted}, 32'd0);
    chk("async_ren",    -2, {31'd0, imemREN}, 32'd0);
    chk("async_addr",   -2, imemaddr, 32'h0);
    @(negedge CLK);
    RST = 1'b0; ihit = 1'b1; imemload = 32'hCAFEF00D;
    #1;
    chk("restart_ren",  -2, {31'd0, imemREN}, 32'd1);
    chk("restart_addr", -2, imemaddr, 32'h0);
    @(posedge CLK);
    #1;
    chk("restart_instr", -2, instr, 32'hCAFEF00D);
    chk("restart_npc",   -2, npc, 32'h4);
    chk("restart_addr4", -2, imemaddr, 32'h4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
